fetch_queue: RTL and testbench

- Instruction fetch front end for the sequential RISC-V core: owns the fetch PC, issues word reads to instruction memory and buffers returned instructions in a small FIFO.
- Feeds the decode/execute stage through a valid/ready handshake; accepts PC redirects (branch/jump targets) from that stage and flushes stale work.
- Sits directly upstream of the sequential datapath and replaces its internal PC and instruction-memory read.

---
 rtl/fetch_queue.sv | 129 ++++++++++++
 tb/tb_fetch_queue.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end for the sequential RISC-V core.
// Owns the fetch PC, issues one word read per cycle to instruction memory
// (fixed one-cycle latency, always accepted) and buffers the returned
// instructions with their PCs in a small FIFO that feeds decode through a
// valid/ready handshake. A redirect from decode/execute flushes the FIFO and
// any outstanding read and restarts fetch at the new (word-aligned) PC.
//
// Ports:
//   clk, rst_n                       clock (rising edge), async active-low reset
//   imem_req_valid, imem_req_addr    read request to instruction memory
//   imem_rsp_valid, imem_rsp_data    read data, one cycle after the request
//   out_valid, out_ready             head-of-queue handshake to decode
//   out_instr, out_pc                head instruction and its PC
//   redirect_valid, redirect_pc      one-cycle restart pulse and target PC
module fetch_queue #(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic               inflight_q, inflight_d;
  logic               drop_q, drop_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   credit;
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic               issue, push, pop;

  // Credit counts buffered entries plus the one read still in flight, so a
  // response always finds a free slot. Pops do not return credit until the
  // next cycle; this keeps the request path free of the out_ready input.
  assign credit = count_q + CNT_W'(inflight_q);
  assign issue  = rst_n && !redirect_valid && (credit < CNT_W'(DEPTH));

  // A response is only kept if it belongs to a live request: the redirect
  // cycle itself and the cycle after it (drop) discard stale data.
  assign push = imem_rsp_valid && inflight_q && !drop_q && !redirect_valid;
  assign pop  = out_valid && out_ready;

  assign imem_req_valid = issue;
  assign imem_req_addr  = fetch_pc_q;
  assign out_valid      = (count_q != '0);
  assign out_instr      = instr_mem_q[rd_ptr_q];
  assign out_pc         = pc_mem_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    drop_d        = 1'b0;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (issue) begin
      fetch_pc_d    = fetch_pc_q + ADDR_W'(4);
      inflight_pc_d = fetch_pc_q;
    end

    if (redirect_valid) begin
      // Redirect wins over everything queued; low bits are forced to a word
      // boundary so a misaligned target still fetches the enclosing word.
      fetch_pc_d = redirect_pc & ~ADDR_W'(3);
      drop_d     = inflight_q;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      drop_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      // Storage is cleared so out_instr/out_pc read as zero out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      drop_q        <= drop_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
        instr_mem_q[wr_ptr_q] <= imem_rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a one-cycle instruction memory model returning
// addr ^ 0x13, a scoreboard of expected {pc, instr} pairs filled on each
// observed request and drained on each decode handshake, and directed
// scenario tasks for reset, streaming, backpressure, redirects and wrap.
module tb_fetch_queue;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n          = 1'b0;
  logic        out_ready      = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc    = 64'h0;

  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  logic        w_req_valid;
  logic [63:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data  = 32'h0;
  logic        w_out_valid;
  logic [31:0] w_out_instr;
  logic [63:0] w_out_pc;

  int checks   = 0;
  int failures = 0;
  int req_cnt  = 0;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] exp_addr = 64'h0;

  fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .out_valid(w_out_valid), .out_ready(1'b1),
    .out_instr(w_out_instr), .out_pc(w_out_pc),
    .redirect_valid(1'b0), .redirect_pc(64'h0)
  );

  // Instruction memory: every request answered one cycle later.
  always @(posedge clk) begin
    imem_rsp_valid <= imem_req_valid;
    imem_rsp_data  <= imem_req_addr[31:0] ^ 32'h13;
    w_rsp_valid    <= w_req_valid;
    w_rsp_data     <= w_req_addr[31:0] ^ 32'h13;
  end

  always @(negedge rst_n) begin
    sb.delete();
    exp_addr = 64'h0;
  end

  // Scoreboard: pops are compared before a redirect flushes, matching the
  // rule that a handshake in the redirect cycle is still consumed.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_pop: got pc=%h instr=%h, required no output", out_pc, out_instr);
        end else begin
          mon_e = sb.pop_front();
          if (out_pc !== mon_e.pc || out_instr !== mon_e.instr) begin
            failures++;
            $display("FAIL sb_pop: got pc=%h instr=%h, required pc=%h instr=%h",
                     out_pc, out_instr, mon_e.pc, mon_e.instr);
          end
        end
      end
      if (redirect_valid) begin
        checks++;
        if (imem_req_valid !== 1'b0) begin
          failures++;
          $display("FAIL req_in_redirect: got req_valid=%b, required 0", imem_req_valid);
        end
        sb.delete();
        exp_addr = redirect_pc & ~64'h3;
      end else if (imem_req_valid) begin
        checks++;
        if (imem_req_addr !== exp_addr) begin
          failures++;
          $display("FAIL req_addr: got %h, required %h", imem_req_addr, exp_addr);
        end
        sb.push_back('{exp_addr, exp_addr[31:0] ^ 32'h13});
        exp_addr = exp_addr + 64'h4;
        req_cnt++;
      end
      checks++;
      if (sb.size() > DEPTH) begin
        failures++;
        $display("FAIL overflow: got %0d outstanding, required <= %0d", sb.size(), DEPTH);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    cyc();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    out_ready = rdy;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: got out_valid=%b req_valid=%b, required 0/0", out_valid, imem_req_valid);
    end
    checks++;
    if (out_instr !== 32'h0 || out_pc !== 64'h0) begin
      failures++;
      $display("FAIL reset_data: got instr=%h pc=%h, required 0/0", out_instr, out_pc);
    end
    checks++;
    if (w_req_valid !== 1'b0 || w_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_wrap_inst: got req=%b out=%b, required 0/0", w_req_valid, w_out_valid);
    end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_c0: got req=%b addr=%h out_valid=%b, required 1/0/0",
               imem_req_valid, imem_req_addr, out_valid);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (imem_req_addr !== 64'h4 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_c1: got addr=%h out_valid=%b, required 4/0", imem_req_addr, out_valid);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== 32'h13) begin
      failures++;
      $display("FAIL stream_first: got valid=%b pc=%h instr=%h, required 1/0/13",
               out_valid, out_pc, out_instr);
    end
    for (int i = 0; i < 12; i++) begin
      cyc();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("FAIL stream_throughput: cycle %0d got out_valid=%b, required 1", i, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int  r0;
    bit  seen;
    do_reset(1'b0);
    r0 = req_cnt;
    repeat (10) cyc();
    @(negedge clk);
    checks++;
    if (req_cnt - r0 != 4 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_credit: got %0d requests req_valid=%b, required 4/0", req_cnt - r0, imem_req_valid);
    end
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h0) begin
      failures++;
      $display("FAIL bp_head: got valid=%b pc=%h, required 1/0", out_valid, out_pc);
    end
    cyc();
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
    checks++;
    if (!seen || imem_req_addr !== 64'h10) begin
      failures++;
      $display("FAIL bp_resume: got seen=%b addr=%h, required 1/10", seen, imem_req_addr);
    end
    repeat (6) cyc();
  endtask

  task automatic wait_out(input string nm, input logic [63:0] pc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
    checks++;
    if (!seen || out_pc !== pc || out_instr !== (pc[31:0] ^ 32'h13)) begin
      failures++;
      $display("FAIL %s: got valid=%b pc=%h instr=%h, required pc=%h", nm, seen, out_pc, out_instr, pc);
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (8) cyc();
    out_ready = 1'b1;
    cyc();
    cyc();
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h100;
    @(negedge clk);
    checks++;
    if (out_pc !== 64'h8 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL redir_setup: got head=%h req=%b, required 8/0", out_pc, imem_req_valid);
    end
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h100) begin
      failures++;
      $display("FAIL redir_r1: got out_valid=%b req=%b addr=%h, required 0/1/100",
               out_valid, imem_req_valid, imem_req_addr);
    end
    cyc();
    out_ready = 1'b1;
    wait_out("redir_first", 64'h100);
    cyc();
    @(negedge clk);
    checks++;
    if (out_pc !== 64'h104) begin
      failures++;
      $display("FAIL redir_second: got pc=%h, required 104", out_pc);
    end
  endtask

  task automatic test_redirect_align();
    do_reset(1'b1);
    repeat (5) cyc();
    redirect_valid = 1'b1;
    redirect_pc = 64'h203;
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h200) begin
      failures++;
      $display("FAIL redir_align: got req=%b addr=%h, required 1/200", imem_req_valid, imem_req_addr);
    end
    cyc();
    wait_out("redir_align_out", 64'h200);
  endtask

  task automatic test_redirect_same();
    logic [63:0] tgt;
    repeat (3) cyc();
    tgt = exp_addr;
    redirect_valid = 1'b1;
    redirect_pc = tgt;
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || imem_req_addr !== tgt) begin
      failures++;
      $display("FAIL redir_same: got out_valid=%b addr=%h, required 0/%h", out_valid, imem_req_addr, tgt);
    end
    cyc();
    wait_out("redir_same_out", tgt);
  endtask

  task automatic test_back_to_back();
    repeat (2) cyc();
    redirect_valid = 1'b1;
    redirect_pc = 64'h300;
    cyc();
    redirect_pc = 64'h400;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_mid: got req=%b out_valid=%b, required 0/0", imem_req_valid, out_valid);
    end
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h400) begin
      failures++;
      $display("FAIL b2b_addr: got req=%b addr=%h, required 1/400", imem_req_valid, imem_req_addr);
    end
    cyc();
    wait_out("b2b_out", 64'h400);
  endtask

  task automatic test_reset_mid();
    repeat (4) cyc();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rmid_pre: got out_valid=%b, required 1", out_valid);
    end
    cyc();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_clear: got out_valid=%b req=%b, required 0/0", out_valid, imem_req_valid);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_rsp_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
      failures++;
      $display("FAIL rmid_stale: got rsp_valid=%b addr=%h, required 1/0", imem_rsp_valid, imem_req_addr);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_nopush: got out_valid=%b, required 0", out_valid);
    end
    cyc();
    wait_out("rmid_refetch", 64'h0);
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    @(negedge clk);
    checks++;
    if (w_req_valid !== 1'b1 || w_req_addr !== WRAP_PC) begin
      failures++;
      $display("FAIL wrap_c0: got req=%b addr=%h, required 1/%h", w_req_valid, w_req_addr, WRAP_PC);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (w_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_c1: got addr=%h, required fffffffffffffffc", w_req_addr);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (w_req_addr !== 64'h0 || w_out_valid !== 1'b1 || w_out_pc !== WRAP_PC ||
        w_out_instr !== 32'hFFFF_FFEB) begin
      failures++;
      $display("FAIL wrap_c2: got addr=%h valid=%b pc=%h instr=%h, required 0/1/%h/ffffffeb",
               w_req_addr, w_out_valid, w_out_pc, w_out_instr, WRAP_PC);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_align();
    test_redirect_same();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
